w5500_spi_slave: RTL and testbench

SPI responder speaking the W5500 frame format: 16-bit address phase, 8-bit control phase, then a data phase. The block is the device-side counterpart of the SPI master used by the socket/initialisation logic, for two uses: a synthesizable W5500 register-file stand-in for loopback bring-up, and the DUT partner in system benches. It oversamples SCK/CS/MOSI in the `clk` domain, decodes each frame, and turns data bytes into single-cycle write strobes or read requests on a byte-wide register-port interface. Read data is shifted out on MISO.

---
 rtl/w5500_spi_slave.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_w5500_spi_slave.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/w5500_spi_slave.sv
// w5500_spi_slave
// ---------------------------------------------------------------------------
// SPI responder (mode 0) that speaks the W5500 frame format: 16-bit address,
// 8-bit control byte (BSB[7:3], RWB[2] 1=write, OM[1:0]), then data bytes.
// SCK/CS/MOSI are oversampled in the clk domain. Data bytes become one-cycle
// write strobes or read requests on a byte-wide register port. Read data is
// shifted out MSB first on MISO.
//
// Optional feature: define W5500_SLV_FDM_EN to honour OM as a fixed data
// length (01=1, 10=2, 11=4 bytes, 00=variable). Without it every frame is
// variable length and the DRAIN state is never entered.
//
// Ports:
//   clk, rst_n          system clock, synchronous active-low reset
//   spi_cs/sck/mosi     SPI inputs, asynchronous to clk
//   o_spi_miso          SPI output, 0 when not shifting read data
//   o_wr_en, o_wr_dat   write strobe and byte
//   o_rd_en, i_rd_dat   read request and data (valid 1 clk after o_rd_en)
//   o_addr, o_bsb       byte address and block select of the current access
//   o_frame_end/err     clean / broken frame termination pulses
// ---------------------------------------------------------------------------
module w5500_spi_slave #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        spi_cs,
   input  logic        spi_sck,
   input  logic        spi_mosi,
   output logic        o_spi_miso,
   output logic        o_wr_en,
   output logic        o_rd_en,
   output logic [15:0] o_addr,
   output logic [4:0]  o_bsb,
   output logic [7:0]  o_wr_dat,
   input  logic [7:0]  i_rd_dat,
   output logic        o_frame_end,
   output logic        o_frame_err
);

   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_CTRL, S_DATA, S_DRAIN} state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
   logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic                   sck_prev_q, sck_prev_d;
   logic                   cs_prev_q, cs_prev_d;
   logic [2:0]             bit_cnt_q, bit_cnt_d;
   logic [2:0]             byte_cnt_q, byte_cnt_d;
   logic [15:0]            rx_sh_q, rx_sh_d;
   logic [7:0]             tx_sh_q, tx_sh_d;
   logic [15:0]            addr_q, addr_d;
   logic [4:0]             bsb_q, bsb_d;
   logic                   rwb_q, rwb_d;
   logic [7:0]             wr_dat_q, wr_dat_d;
   logic                   wr_en_q, wr_en_d;
   logic                   rd_en_q, rd_en_d;
   logic                   rd_dly_q, rd_dly_d;
   logic                   miso_q, miso_d;
   logic                   frame_end_q, frame_end_d;
   logic                   frame_err_q, frame_err_d;
`ifdef W5500_SLV_FDM_EN
   logic [1:0]             om_q, om_d;
   logic [2:0]             byte_limit;
`endif

   logic sck_s, cs_s, mosi_s;
   logic sck_rise, sck_fall, cs_fall, cs_rise;
   logic last_byte;

   assign sck_s    = sck_sync_q[SYNC_STAGES-1];
   assign cs_s     = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_prev_q;
   assign sck_fall = ~sck_s & sck_prev_q;
   assign cs_fall  = ~cs_s & cs_prev_q;
   assign cs_rise  = cs_s & ~cs_prev_q;

   // Synchronizers and edge-detect history. Reset to 0 so that a reset taken
   // while CS is low never looks like a CS fall; a CS rise seen in IDLE is
   // simply ignored.
   always_comb begin
      sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sck_prev_d  = sck_s;
      cs_prev_d   = cs_s;
   end

   // Fixed-length data phase: the byte that reaches the OM limit is the last.
`ifdef W5500_SLV_FDM_EN
   always_comb begin
      case (om_q)
         2'b01:   byte_limit = 3'd1;
         2'b10:   byte_limit = 3'd2;
         2'b11:   byte_limit = 3'd4;
         default: byte_limit = 3'd0;
      endcase
      last_byte = (om_q != 2'b00) && ((byte_cnt_q + 3'd1) == byte_limit);
   end
`else
   assign last_byte = 1'b0;
`endif

   // Frame decoder: next state, counters, shift registers and strobes.
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      byte_cnt_d  = byte_cnt_q;
      rx_sh_d     = rx_sh_q;
      tx_sh_d     = tx_sh_q;
      addr_d      = addr_q;
      bsb_d       = bsb_q;
      rwb_d       = rwb_q;
      wr_dat_d    = wr_dat_q;
      wr_en_d     = 1'b0;
      rd_en_d     = 1'b0;
      rd_dly_d    = rd_en_q;
      miso_d      = miso_q;
      frame_end_d = 1'b0;
      frame_err_d = 1'b0;
`ifdef W5500_SLV_FDM_EN
      om_d        = om_q;
`endif

      // Write address advances the cycle after its strobe.
      if (wr_en_q) begin
         addr_d = addr_q + 16'd1;
      end

      case (state_q)
         S_IDLE: begin
            miso_d = 1'b0;
            if (cs_fall) begin
               state_d    = S_ADDR;
               bit_cnt_d  = 3'd0;
               byte_cnt_d = 3'd0;
            end
         end
         S_ADDR: begin
            if (sck_rise) begin
               rx_sh_d   = {rx_sh_q[14:0], mosi_s};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  if (byte_cnt_q == 3'd1) begin
                     addr_d     = {rx_sh_q[14:0], mosi_s};
                     byte_cnt_d = 3'd0;
                     state_d    = S_CTRL;
                  end else begin
                     byte_cnt_d = byte_cnt_q + 3'd1;
                  end
               end
            end
         end
         S_CTRL: begin
            if (sck_rise) begin
               rx_sh_d   = {rx_sh_q[14:0], mosi_s};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  bsb_d   = rx_sh_q[6:2];
                  rwb_d   = rx_sh_q[1];
                  rd_en_d = ~rx_sh_q[1];
`ifdef W5500_SLV_FDM_EN
                  om_d    = {rx_sh_q[0], mosi_s};
`endif
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (rwb_q) begin
               miso_d = 1'b0;
            end else if (sck_fall) begin
               miso_d  = tx_sh_q[7];
               tx_sh_d = {tx_sh_q[6:0], 1'b0};
            end
            if (sck_rise) begin
               rx_sh_d   = {rx_sh_q[14:0], mosi_s};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  byte_cnt_d = byte_cnt_q + 3'd1;
                  if (rwb_q) begin
                     wr_en_d  = 1'b1;
                     wr_dat_d = {rx_sh_q[6:0], mosi_s};
                  end else begin
                     // Prefetch the next byte unless the fixed length is done.
                     addr_d  = addr_q + 16'd1;
                     rd_en_d = ~last_byte;
                  end
                  if (last_byte) begin
                     state_d = S_DRAIN;
                  end
               end
            end
         end
         S_DRAIN: begin
            miso_d = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Read data arrives one cycle after the request; load wins over a shift.
      if (rd_dly_q) begin
         tx_sh_d = i_rd_dat;
      end

      // CS rise ends any frame immediately; a partial byte is never written.
      if (cs_rise && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         miso_d  = 1'b0;
         wr_en_d = 1'b0;
         rd_en_d = 1'b0;
         if (((state_q == S_DATA) || (state_q == S_DRAIN)) && (bit_cnt_q == 3'd0)) begin
            frame_end_d = 1'b1;
         end else begin
            frame_err_d = 1'b1;
         end
      end
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         sck_sync_q  <= '0;
         cs_sync_q   <= '0;
         mosi_sync_q <= '0;
         sck_prev_q  <= 1'b0;
         cs_prev_q   <= 1'b0;
         bit_cnt_q   <= 3'd0;
         byte_cnt_q  <= 3'd0;
         rx_sh_q     <= 16'd0;
         tx_sh_q     <= 8'd0;
         addr_q      <= 16'd0;
         bsb_q       <= 5'd0;
         rwb_q       <= 1'b0;
         wr_dat_q    <= 8'd0;
         wr_en_q     <= 1'b0;
         rd_en_q     <= 1'b0;
         rd_dly_q    <= 1'b0;
         miso_q      <= 1'b0;
         frame_end_q <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef W5500_SLV_FDM_EN
         om_q        <= 2'b00;
`endif
      end else begin
         state_q     <= state_d;
         sck_sync_q  <= sck_sync_d;
         cs_sync_q   <= cs_sync_d;
         mosi_sync_q <= mosi_sync_d;
         sck_prev_q  <= sck_prev_d;
         cs_prev_q   <= cs_prev_d;
         bit_cnt_q   <= bit_cnt_d;
         byte_cnt_q  <= byte_cnt_d;
         rx_sh_q     <= rx_sh_d;
         tx_sh_q     <= tx_sh_d;
         addr_q      <= addr_d;
         bsb_q       <= bsb_d;
         rwb_q       <= rwb_d;
         wr_dat_q    <= wr_dat_d;
         wr_en_q     <= wr_en_d;
         rd_en_q     <= rd_en_d;
         rd_dly_q    <= rd_dly_d;
         miso_q      <= miso_d;
         frame_end_q <= frame_end_d;
         frame_err_q <= frame_err_d;
`ifdef W5500_SLV_FDM_EN
         om_q        <= om_d;
`endif
      end
   end

   assign o_spi_miso  = miso_q;
   assign o_wr_en     = wr_en_q;
   assign o_rd_en     = rd_en_q;
   assign o_addr      = addr_q;
   assign o_bsb       = bsb_q;
   assign o_wr_dat    = wr_dat_q;
   assign o_frame_end = frame_end_q;
   assign o_frame_err = frame_err_q;

endmodule

// File: tb/tb_w5500_spi_slave.sv
// Bench for w5500_spi_slave: a bit-banged SPI master drives W5500 frames,
// a register-port model answers reads with addr[7:0], and a scoreboard of
// expected write/read/frame-event records is consumed as strobes appear.
module tb_w5500_spi_slave;

   localparam int HALF = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        spi_cs = 1'b1;
   logic        spi_sck = 1'b0;
   logic        spi_mosi = 1'b0;
   logic        o_spi_miso;
   logic        o_wr_en;
   logic        o_rd_en;
   logic [15:0] o_addr;
   logic [4:0]  o_bsb;
   logic [7:0]  o_wr_dat;
   logic [7:0]  i_rd_dat = 8'd0;
   logic        o_frame_end;
   logic        o_frame_err;

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  dat;
      logic [4:0]  bsb;
   } acc_t;

   acc_t       expWrQ[$];
   acc_t       expRdQ[$];
   logic [1:0] expEvQ[$];
   int         numChecks = 0;
   int         numFails = 0;
   logic [7:0] txData[8];
   logic [7:0] rxData[8];

   w5500_spi_slave #(.SYNC_STAGES(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .spi_cs      (spi_cs),
      .spi_sck     (spi_sck),
      .spi_mosi    (spi_mosi),
      .o_spi_miso  (o_spi_miso),
      .o_wr_en     (o_wr_en),
      .o_rd_en     (o_rd_en),
      .o_addr      (o_addr),
      .o_bsb       (o_bsb),
      .o_wr_dat    (o_wr_dat),
      .i_rd_dat    (i_rd_dat),
      .o_frame_end (o_frame_end),
      .o_frame_err (o_frame_err)
   );

   // System clock.
   always #5 clk = ~clk;

   // Register-file model: returns the low address byte one clock after a request.
   always @(posedge clk) begin
      if (o_rd_en) begin
         i_rd_dat <= o_addr[7:0];
      end
   end

   // Single comparison point: counts and reports.
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      numChecks++;
      if (got !== exp) begin
         numFails++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] outBundle();
      return {30'd0, o_spi_miso, o_wr_en, o_rd_en, o_addr, o_bsb, o_wr_dat, o_frame_end, o_frame_err};
   endfunction

   function automatic acc_t mkAcc(input logic [15:0] a, input logic [7:0] d, input logic [4:0] b);
      acc_t r;
      r.addr = a;
      r.dat  = d;
      r.bsb  = b;
      return r;
   endfunction

   // Scoreboard consumer: sampled on the falling clock edge.
   always @(negedge clk) begin
      acc_t e;
      if (rst_n) begin
         if (o_wr_en) begin
            checkOutput("wr_expected", expWrQ.size() > 0, 1);
            if (expWrQ.size() > 0) begin
               e = expWrQ.pop_front();
               checkOutput("wr_addr", o_addr, e.addr);
               checkOutput("wr_dat", o_wr_dat, e.dat);
               checkOutput("wr_bsb", o_bsb, e.bsb);
            end
         end
         if (o_rd_en) begin
            checkOutput("rd_expected", expRdQ.size() > 0, 1);
            if (expRdQ.size() > 0) begin
               e = expRdQ.pop_front();
               checkOutput("rd_addr", o_addr, e.addr);
               checkOutput("rd_bsb", o_bsb, e.bsb);
            end
         end
         if (o_frame_end || o_frame_err) begin
            checkOutput("ev_expected", expEvQ.size() > 0, 1);
            if (expEvQ.size() > 0) begin
               checkOutput("frame_event", {o_frame_err, o_frame_end}, expEvQ.pop_front());
            end
         end
      end
   end

   // One SPI mode-0 bit: MISO sampled just before the rising SCK edge.
   task automatic spiBit(input logic b, output logic m);
      spi_mosi = b;
      repeat (HALF) @(negedge clk);
      m = o_spi_miso;
      spi_sck = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_sck = 1'b0;
   endtask

   // Drive nBits of {addr, ctrl, txData...}, capture MISO, optionally end with CS rise.
   task automatic shiftFrame(input logic [15:0] addr, input logic [7:0] ctrl, input int nBits);
      logic [23:0] hdr;
      logic        b;
      logic        m;
      hdr = {addr, ctrl};
      for (int k = 0; k < 8; k++) rxData[k] = 8'd0;
      spi_cs = 1'b0;
      repeat (HALF) @(negedge clk);
      for (int i = 0; i < nBits; i++) begin
         if (i < 24) b = hdr[23 - i];
         else        b = txData[(i - 24) / 8][7 - ((i - 24) % 8)];
         spiBit(b, m);
         if (i >= 24) rxData[(i - 24) / 8][7 - ((i - 24) % 8)] = m;
      end
      repeat (HALF) @(negedge clk);
   endtask

   task automatic applyStimulus(input logic [15:0] addr, input logic [7:0] ctrl, input int nBits);
      shiftFrame(addr, ctrl, nBits);
      spi_cs = 1'b1;
      repeat (16) @(negedge clk);
   endtask

   task automatic checkQueues(input string tag);
      checkOutput({tag, "_wr_left"}, expWrQ.size(), 0);
      checkOutput({tag, "_rd_left"}, expRdQ.size(), 0);
      checkOutput({tag, "_ev_left"}, expEvQ.size(), 0);
   endtask

   // Watchdog so a stuck run still ends.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] time limit expired");
   end

   initial begin
      $display("[TB] start");
      repeat (3) @(negedge clk);
      checkOutput("reset_outputs", outBundle(), 64'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Write frame, BSB=1, two bytes.
      txData[0] = 8'hA5;
      txData[1] = 8'h5A;
      expWrQ.push_back(mkAcc(16'h0010, 8'hA5, 5'd1));
      expWrQ.push_back(mkAcc(16'h0011, 8'h5A, 5'd1));
      expEvQ.push_back(2'b01);
      applyStimulus(16'h0010, 8'h0C, 24 + 16);
      checkQueues("write");

      // Read frame, three bytes plus a trailing prefetch.
      for (int k = 0; k < 4; k++) expRdQ.push_back(mkAcc(16'h0039 + 16'(k), 8'd0, 5'd1));
      expEvQ.push_back(2'b01);
      applyStimulus(16'h0039, 8'h08, 24 + 24);
      checkOutput("miso_b0", rxData[0], 8'h39);
      checkOutput("miso_b1", rxData[1], 8'h3A);
      checkOutput("miso_b2", rxData[2], 8'h3B);
      checkQueues("read");

      // Address wrap.
      txData[0] = 8'hC3;
      txData[1] = 8'h3C;
      expWrQ.push_back(mkAcc(16'hFFFF, 8'hC3, 5'd0));
      expWrQ.push_back(mkAcc(16'h0000, 8'h3C, 5'd0));
      expEvQ.push_back(2'b01);
      applyStimulus(16'hFFFF, 8'h04, 24 + 16);
      checkQueues("wrap");

      // OM=10 with four bytes clocked.
      txData[0] = 8'h11;
      txData[1] = 8'h22;
      txData[2] = 8'h33;
      txData[3] = 8'h44;
      expWrQ.push_back(mkAcc(16'h0200, 8'h11, 5'd0));
      expWrQ.push_back(mkAcc(16'h0201, 8'h22, 5'd0));
`ifndef W5500_SLV_FDM_EN
      expWrQ.push_back(mkAcc(16'h0202, 8'h33, 5'd0));
      expWrQ.push_back(mkAcc(16'h0203, 8'h44, 5'd0));
`endif
      expEvQ.push_back(2'b01);
      applyStimulus(16'h0200, 8'h06, 24 + 32);
      checkOutput("fdm_miso_b2", rxData[2], 8'h00);
      checkOutput("fdm_miso_b3", rxData[3], 8'h00);
      checkQueues("fdm");

      // Abort after 13 control/data bits, then a clean frame.
      txData[0] = 8'hFF;
      expEvQ.push_back(2'b10);
      applyStimulus(16'h0300, 8'h04, 24 + 5);
      checkQueues("abort");
      txData[0] = 8'hEE;
      expWrQ.push_back(mkAcc(16'h0300, 8'hEE, 5'd0));
      expEvQ.push_back(2'b01);
      applyStimulus(16'h0300, 8'h04, 24 + 8);
      checkQueues("after_abort");

      // Abort in the address phase.
      expEvQ.push_back(2'b10);
      applyStimulus(16'h1234, 8'h04, 10);
      checkQueues("addr_abort");

      // Reset mid data byte.
      txData[0] = 8'h77;
      txData[1] = 8'hF0;
      expWrQ.push_back(mkAcc(16'h0100, 8'h77, 5'd0));
      shiftFrame(16'h0100, 8'h04, 24 + 12);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checkOutput("midframe_reset", outBundle(), 64'd0);
      spi_cs = 1'b1;
      repeat (16) @(negedge clk);
      checkQueues("reset");
      txData[0] = 8'h9C;
      expWrQ.push_back(mkAcc(16'h0123, 8'h9C, 5'd1));
      expEvQ.push_back(2'b01);
      applyStimulus(16'h0123, 8'h0C, 24 + 8);
      checkQueues("post_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
      $finish;
   end

endmodule
